// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
//   Time-multiplexed driver for a 4-digit, 7-segment display with BCD inputs.
//   A prescaler holds each digit for REFRESH_DIV clocks. The four digits and
//   their decimal-point requests are captured into a snapshot once per frame,
//   so a frame never mixes old and new input values.
//
//   Optional feature (compile-time macro SEG_LEADING_ZERO_BLANK_EN):
//     suppress leading zero digits 3..1 unless their decimal point is
//     requested. Digit 0 is always shown.
//
// Parameters
//   REFRESH_DIV    clocks per digit, 1..65535
//
// Ports
//   clk_i          clock, rising edge
//   reset_i        synchronous active-high reset
//   d0_i..d3_i     BCD digits, d0 rightmost
//   dp_en_i[3:0]   decimal-point request per digit
//   blank_i        forces all digit selects off
//   seg_o[6:0]     segments {g,f,e,d,c,b,a}, active-high, registered
//   an_o[3:0]      digit selects, active-low, registered
//   dp_o           decimal point, active-high, registered
//   frame_start_o  one-cycle pulse following each snapshot capture
// ---------------------------------------------------------------------------
module seg_scan_driver #(
  parameter int unsigned REFRESH_DIV = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] d0_i,
  input  logic [3:0] d1_i,
  input  logic [3:0] d2_i,
  input  logic [3:0] d3_i,
  input  logic [3:0] dp_en_i,
  input  logic       blank_i,
  output logic [6:0] seg_o,
  output logic [3:0] an_o,
  output logic       dp_o,
  output logic       frame_start_o
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          start_q;
  logic [15:0]   snap_dig_q, snap_dig_d;
  logic [3:0]    snap_dp_q, snap_dp_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          dp_q, dp_d;
  logic          fs_q, fs_d;

  logic          wrap;
  logic          frame_evt;
  logic [3:0]    digit;
  logic [6:0]    seg_dec;
  logic          suppress;

  // start_q marks the first edge after reset: that edge opens a frame on
  // digit 0 with the prescaler at 0, so the first frame is as long as every
  // later one.
  always_comb begin
    wrap      = (cnt_q == CNT_LAST);
    frame_evt = start_q | (wrap & (idx_q == 2'd3));

    if (start_q) begin
      cnt_d = '0;
      idx_d = 2'd0;
    end else begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      idx_d = wrap ? idx_q + 2'd1 : idx_q;
    end

    if (frame_evt) begin
      snap_dig_d = {d3_i, d2_i, d1_i, d0_i};
      snap_dp_d  = dp_en_i;
    end else begin
      snap_dig_d = snap_dig_q;
      snap_dp_d  = snap_dp_q;
    end
    fs_d = frame_evt;
  end

  // Outputs are decoded from the next index and next snapshot so a digit
  // appears in the same cycle its index is registered.
  always_comb begin
    digit = snap_dig_d[{idx_d, 2'b00} +: 4];
    case (digit)
      4'd0:    seg_dec = 7'h3F;
      4'd1:    seg_dec = 7'h06;
      4'd2:    seg_dec = 7'h5B;
      4'd3:    seg_dec = 7'h4F;
      4'd4:    seg_dec = 7'h66;
      4'd5:    seg_dec = 7'h6D;
      4'd6:    seg_dec = 7'h7D;
      4'd7:    seg_dec = 7'h07;
      4'd8:    seg_dec = 7'h7F;
      4'd9:    seg_dec = 7'h6F;
      default: seg_dec = 7'h40;
    endcase

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and everything to its left is zero.
    case (idx_d)
      2'd3:    suppress = (snap_dig_d[15:12] == 4'd0)  & ~snap_dp_d[3];
      2'd2:    suppress = (snap_dig_d[15:8]  == 8'd0)  & ~snap_dp_d[2];
      2'd1:    suppress = (snap_dig_d[15:4]  == 12'd0) & ~snap_dp_d[1];
      default: suppress = 1'b0;
    endcase
`else
    suppress = 1'b0;
`endif

    if (blank_i || suppress) begin
      seg_d = 7'h00;
      an_d  = 4'b1111;
      dp_d  = 1'b0;
    end else begin
      seg_d = seg_dec;
      an_d  = ~(4'b0001 << idx_d);
      dp_d  = snap_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      start_q    <= 1'b1;
      snap_dig_q <= 16'd0;
      snap_dp_q  <= 4'd0;
      seg_q      <= 7'h00;
      an_q       <= 4'b1111;
      dp_q       <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      start_q    <= 1'b0;
      snap_dig_q <= snap_dig_d;
      snap_dp_q  <= snap_dp_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      dp_q       <= dp_d;
      fs_q       <= fs_d;
    end
  end

  assign seg_o         = seg_q;
  assign an_o          = an_q;
  assign dp_o          = dp_q;
  assign frame_start_o = fs_q;

endmodule
